gate_deadtime: RTL and testbench

GATE_DEADTIME -- requirements
Module: gate_deadtime

---
 rtl/gate_deadtime.sv | 126 ++++++++++++
 tb/tb_gate_deadtime.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/gate_deadtime.sv
// Dead-time inserter for two half-bridge legs: each leg is gated by its own
// FSM so the high and low switches never conduct together.
module gate_deadtime #(
  parameter int unsigned DEADTIME = 20,
  parameter int unsigned MIN_ON   = 10
) (
  input  logic       i_clock,
  input  logic       i_RESET,
  input  logic [3:0] i_MOSFET,
  output logic [3:0] o_GATE,
  output logic [1:0] o_fault,
  output logic [1:0] o_dead
);

  typedef enum logic [2:0] {S_OFF, S_HI_ON, S_LO_ON, S_DEAD, S_FAULT} leg_state_e;
  // Encoded as {lo, hi} so a leg's command pair casts straight into a request.
  typedef enum logic [1:0] {REQ_OFF = 2'b00, REQ_HI = 2'b01, REQ_LO = 2'b10, REQ_ILL = 2'b11} leg_req_e;

  localparam logic [7:0] DEAD_LOAD = 8'(DEADTIME);
  localparam logic [7:0] MIN_ON_T  = 8'(MIN_ON);

  logic [3:0] cmd_q;
  leg_state_e state_q    [2];
  leg_state_e state_d    [2];
  logic [7:0] dead_cnt_q [2];
  logic [7:0] dead_cnt_d [2];
  logic [7:0] on_cnt_q   [2];
  logic [7:0] on_cnt_d   [2];
  logic [3:0] gate_q, gate_d;
  logic [1:0] fault_q, fault_d;
  logic [1:0] dead_q, dead_d;

  always_comb begin
    leg_req_e req;
    leg_req_e own;
    // NOTE: every variable gets its hold/default value before any branch, so no path infers a latch.
    req     = REQ_OFF;
    own     = REQ_OFF;
    gate_d  = '0;
    dead_d  = '0;
    fault_d = fault_q;
    for (int l = 0; l < 2; l++) begin
      state_d[l]    = state_q[l];
      dead_cnt_d[l] = dead_cnt_q[l];
      on_cnt_d[l]   = on_cnt_q[l];
      req = leg_req_e'({cmd_q[l+2], cmd_q[l]});
      own = (state_q[l] == S_HI_ON) ? REQ_HI : REQ_LO;

      if (req == REQ_ILL) begin
        state_d[l] = S_FAULT;
      end else begin
        case (state_q[l])
          S_OFF: begin
            if (req != REQ_OFF) begin
              state_d[l]    = S_DEAD;
              dead_cnt_d[l] = DEAD_LOAD;
            end
          end
          S_HI_ON, S_LO_ON: begin
            on_cnt_d[l] = (on_cnt_q[l] == 8'hFF) ? 8'hFF : on_cnt_q[l] + 8'd1;
            if (req == REQ_OFF) begin
              state_d[l] = S_OFF;
            end else if (req != own && on_cnt_q[l] >= MIN_ON_T) begin
              state_d[l]    = S_DEAD;
              dead_cnt_d[l] = DEAD_LOAD;
            end
          end
          S_DEAD: begin
            // Exit side is whatever is requested on the last dead cycle.
            if (dead_cnt_q[l] <= 8'd1) begin
              dead_cnt_d[l] = 8'd0;
              on_cnt_d[l]   = 8'd0;
              case (req)
                REQ_HI:  state_d[l] = S_HI_ON;
                REQ_LO:  state_d[l] = S_LO_ON;
                default: state_d[l] = S_OFF;
              endcase
            end else begin
              dead_cnt_d[l] = dead_cnt_q[l] - 8'd1;
            end
          end
          default: state_d[l] = S_FAULT;
        endcase
      end

      fault_d[l]  = fault_q[l] | (state_d[l] == S_FAULT);
      dead_d[l]   = (state_d[l] == S_DEAD);
      gate_d[l]   = (state_d[l] == S_HI_ON);
      gate_d[l+2] = (state_d[l] == S_LO_ON);
    end
  end

  // Outputs are registered from next state so gates drop with the state change.
  always_ff @(posedge i_clock or posedge i_RESET) begin
    if (i_RESET) begin
      cmd_q   <= '0;
      gate_q  <= '0;
      fault_q <= '0;
      dead_q  <= '0;
      for (int l = 0; l < 2; l++) begin
        state_q[l]    <= S_OFF;
        dead_cnt_q[l] <= '0;
        on_cnt_q[l]   <= '0;
      end
    end else begin
      // NOTE: non-blocking updates so every flop samples the pre-edge values.
      cmd_q   <= i_MOSFET;
      gate_q  <= gate_d;
      fault_q <= fault_d;
      dead_q  <= dead_d;
      for (int l = 0; l < 2; l++) begin
        state_q[l]    <= state_d[l];
        dead_cnt_q[l] <= dead_cnt_d[l];
        on_cnt_q[l]   <= on_cnt_d[l];
      end
    end
  end

  assign o_GATE  = gate_q;
  assign o_fault = fault_q;
  assign o_dead  = dead_q;

  a_no_shoot_through : assert property (@(posedge i_clock) disable iff (i_RESET)
    !(o_GATE[0] && o_GATE[2]) && !(o_GATE[1] && o_GATE[3]));

endmodule

// File: tb/tb_gate_deadtime.sv
// Directed table of {command, hold cycles, expected outputs} plus async-reset
// sequences and a randomized shoot-through / dead-gap monitor.
module tb_gate_deadtime;

  localparam int DEADTIME = 20;

  // Bit mapping: leg A hi=bit0 lo=bit2, leg B hi=bit1 lo=bit3.
  localparam logic [3:0] A_LO_B_LO  = 4'b1100;
  localparam logic [3:0] A_LO_B_HI  = 4'b0110;
  localparam logic [3:0] A_HI_B_LO  = 4'b1001;
  localparam logic [3:0] B_LO       = 4'b1000;
  localparam logic [3:0] A_LO       = 4'b0100;
  localparam logic [3:0] A_HI       = 4'b0001;
  localparam logic [3:0] A_HI_B_ILL = 4'b1011;
  localparam logic [3:0] A_HI_B_HI  = 4'b0011;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] mosfet;
  logic [3:0] gate;
  logic [1:0] fault;
  logic [1:0] dead;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [3:0] cmd;
    int         cycles;
    logic [3:0] gate;
    logic [1:0] fault;
    logic [1:0] dead;
  } vec_t;

  vec_t vecs[$];

  gate_deadtime #(.DEADTIME(DEADTIME), .MIN_ON(10)) dut (
    .i_clock  (clk),
    .i_RESET  (rst),
    .i_MOSFET (mosfet),
    .o_GATE   (gate),
    .o_fault  (fault),
    .o_dead   (dead)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_outs(input string tag, input logic [3:0] g, input logic [1:0] f, input logic [1:0] d);
    check({tag, ".gate"},  {4'b0, gate},  {4'b0, g});
    check({tag, ".fault"}, {6'b0, fault}, {6'b0, f});
    check({tag, ".dead"},  {6'b0, dead},  {6'b0, d});
  endtask

  // Random-phase monitor: no overlap, and every turn-on preceded by >= DEADTIME idle cycles.
  logic mon_en = 1'b0;
  int   zero_run [2];
  logic prev_on  [2];

  always @(negedge clk) begin
    if (mon_en) begin
      for (int l = 0; l < 2; l++) begin
        logic on;
        on = gate[l] | gate[l+2];
        check($sformatf("overlap_leg%0d", l), {7'b0, gate[l] & gate[l+2]}, 8'd0);
        if (on && !prev_on[l])
          check($sformatf("deadgap_leg%0d_run%0d", l, zero_run[l]), {7'b0, zero_run[l] >= DEADTIME}, 8'd1);
        zero_run[l] = on ? 0 : zero_run[l] + 1;
        prev_on[l]  = on;
      end
    end
  end

  initial begin
    // Reset release with both legs requesting the low side.
    vecs.push_back('{A_LO_B_LO,  1, 4'b0000, 2'b00, 2'b00});
    vecs.push_back('{A_LO_B_LO,  1, 4'b0000, 2'b00, 2'b11});
    vecs.push_back('{A_LO_B_LO, 19, 4'b0000, 2'b00, 2'b11});
    vecs.push_back('{A_LO_B_LO,  1, 4'b1100, 2'b00, 2'b00});
    vecs.push_back('{A_LO_B_LO, 12, 4'b1100, 2'b00, 2'b00});
    // Leg B low -> high commutation; leg A untouched.
    vecs.push_back('{A_LO_B_HI,  1, 4'b1100, 2'b00, 2'b00});
    vecs.push_back('{A_LO_B_HI,  1, 4'b0100, 2'b00, 2'b10});
    vecs.push_back('{A_LO_B_HI, 19, 4'b0100, 2'b00, 2'b10});
    vecs.push_back('{A_LO_B_HI,  1, 4'b0110, 2'b00, 2'b00});
    vecs.push_back('{A_LO_B_HI,  4, 4'b0110, 2'b00, 2'b00});
    // Leg B back to low 5 cycles after entry: held by the on-timer until it reaches 10.
    vecs.push_back('{A_LO_B_LO,  1, 4'b0110, 2'b00, 2'b00});
    vecs.push_back('{A_LO_B_LO,  5, 4'b0110, 2'b00, 2'b00});
    vecs.push_back('{A_LO_B_LO,  1, 4'b0100, 2'b00, 2'b10});
    vecs.push_back('{A_LO_B_LO, 19, 4'b0100, 2'b00, 2'b10});
    vecs.push_back('{A_LO_B_LO,  1, 4'b1100, 2'b00, 2'b00});
    // Leg A reversal at dead cycle 7 still waits out the whole interval.
    vecs.push_back('{A_HI_B_LO,  1, 4'b1100, 2'b00, 2'b00});
    vecs.push_back('{A_HI_B_LO,  1, 4'b1000, 2'b00, 2'b01});
    vecs.push_back('{A_HI_B_LO,  6, 4'b1000, 2'b00, 2'b01});
    vecs.push_back('{A_LO_B_LO, 13, 4'b1000, 2'b00, 2'b01});
    vecs.push_back('{A_LO_B_LO,  1, 4'b1100, 2'b00, 2'b00});
    // OFF request right after turn-on ignores the minimum on time.
    vecs.push_back('{B_LO,       1, 4'b1100, 2'b00, 2'b00});
    vecs.push_back('{B_LO,       1, 4'b1000, 2'b00, 2'b00});
    // Leg B illegal while leg A starts a high-side turn-on.
    vecs.push_back('{A_HI_B_ILL, 1, 4'b1000, 2'b00, 2'b00});
    vecs.push_back('{A_HI_B_ILL, 1, 4'b0000, 2'b10, 2'b01});
    vecs.push_back('{A_HI_B_ILL,19, 4'b0000, 2'b10, 2'b01});
    vecs.push_back('{A_HI_B_ILL, 1, 4'b0001, 2'b10, 2'b00});
    vecs.push_back('{A_HI_B_HI, 25, 4'b0001, 2'b10, 2'b00});

    rst    = 1'b1;
    mosfet = vecs[0].cmd;
    repeat (3) @(negedge clk);
    check_outs("reset", 4'b0000, 2'b00, 2'b00);
    rst = 1'b0;

    foreach (vecs[i]) begin
      mosfet = vecs[i].cmd;
      repeat (vecs[i].cycles) @(posedge clk);
      @(negedge clk);
      check_outs($sformatf("vec%0d", i), vecs[i].gate, vecs[i].fault, vecs[i].dead);
    end

    // Async reset while leg A is on clears gates and the sticky fault without an edge.
    #2 rst = 1'b1;
    #1 check_outs("async_rst_on", 4'b0000, 2'b00, 2'b00);
    @(negedge clk);
    mosfet = A_HI_B_HI;
    rst    = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk);
    check_outs("rst2_dead", 4'b0000, 2'b00, 2'b11);
    // Async reset in the middle of a dead interval.
    #2 rst = 1'b1;
    #1 check_outs("async_rst_dead", 4'b0000, 2'b00, 2'b00);
    @(negedge clk);
    rst = 1'b0;
    repeat (21) @(posedge clk);
    @(negedge clk);
    check_outs("rst3_edge21", 4'b0000, 2'b00, 2'b11);
    @(posedge clk);
    @(negedge clk);
    check_outs("rst3_edge22", 4'b0011, 2'b00, 2'b00);

    // Randomized legal commands with pulses of 1..30 cycles.
    rst    = 1'b1;
    mosfet = 4'b0000;
    @(negedge clk);
    rst = 1'b0;
    for (int l = 0; l < 2; l++) begin
      zero_run[l] = 0;
      prev_on[l]  = 1'b0;
    end
    mon_en = 1'b1;
    for (int seg = 0; seg < 1500; seg++) begin
      int unsigned ra, rb;
      ra = $urandom_range(0, 2);
      rb = $urandom_range(0, 2);
      mosfet = {rb == 2, ra == 2, rb == 1, ra == 1};
      repeat ($urandom_range(1, 30)) @(negedge clk);
    end
    mon_en = 1'b0;
    check("random_no_fault", {6'b0, fault}, 8'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
